// File: rtl/ber_sweep_seq.sv
// ber_sweep_seq: steps MAIN_MODE/SUB_MODE through a host-programmed range for the
// stimulus/LVDS BER block. Each point is a settle window (CLR high) followed by a
// dwell (CLR low); at the end of the dwell the error counters are snapshotted into
// a result record handed downstream over valid/ready.
module ber_sweep_seq #(
  parameter int unsigned SETTLE    = 16,
  parameter int unsigned DWELL_W   = 32,
  parameter logic [7:0]  IDLE_MODE = 8'd0
) (
  input  logic               RSTX,
  input  logic               CLK,
  input  logic               START,
  input  logic               ABORT,
  input  logic [7:0]         MAIN_FIRST,
  input  logic [7:0]         MAIN_LAST,
  input  logic [7:0]         SUB_LAST,
  input  logic [DWELL_W-1:0] DWELL,
  output logic [7:0]         MAIN_MODE,
  output logic [7:0]         SUB_MODE,
  output logic               CLR,
  input  logic [57:0]        RECV_CNT,
  input  logic [63:0]        ERR_CNT,
  output logic               RES_VALID,
  input  logic               RES_READY,
  output logic [7:0]         RES_MAIN,
  output logic [7:0]         RES_SUB,
  output logic [57:0]        RES_RECV,
  output logic [63:0]        RES_ERR,
  output logic               RES_LAST,
  output logic               BUSY,
  output logic               DONE,
  output logic               ABORTED
);

  localparam int unsigned SET_W = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DWELL  = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t             r_state,     w_state;
  logic [7:0]         r_main,      w_main;
  logic [7:0]         r_sub,       w_sub;
  logic               r_clr,       w_clr;
  logic               r_res_valid, w_res_valid;
  logic [7:0]         r_res_main,  w_res_main;
  logic [7:0]         r_res_sub,   w_res_sub;
  logic [57:0]        r_res_recv,  w_res_recv;
  logic [63:0]        r_res_err,   w_res_err;
  logic               r_res_last,  w_res_last;
  logic               r_busy,      w_busy;
  logic               r_done,      w_done;
  logic               r_aborted,   w_aborted;
  logic [7:0]         r_main_last, w_main_last;
  logic [7:0]         r_sub_last,  w_sub_last;
  logic [DWELL_W-1:0] r_dwell,     w_dwell;
  logic [SET_W-1:0]   r_set_cnt,   w_set_cnt;
  logic [DWELL_W-1:0] r_dwl_cnt,   w_dwl_cnt;

  // State and output registers; reset leaves the stimulus block cleared and idle.
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      r_state     <= S_IDLE;
      r_main      <= IDLE_MODE;
      r_sub       <= 8'd0;
      r_clr       <= 1'b1;
      r_res_valid <= 1'b0;
      r_res_main  <= 8'd0;
      r_res_sub   <= 8'd0;
      r_res_recv  <= 58'd0;
      r_res_err   <= 64'd0;
      r_res_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_main_last <= 8'd0;
      r_sub_last  <= 8'd0;
      r_dwell     <= DWELL_W'(1);
      r_set_cnt   <= SET_W'(0);
      r_dwl_cnt   <= DWELL_W'(0);
    end else begin
      r_state     <= w_state;
      r_main      <= w_main;
      r_sub       <= w_sub;
      r_clr       <= w_clr;
      r_res_valid <= w_res_valid;
      r_res_main  <= w_res_main;
      r_res_sub   <= w_res_sub;
      r_res_recv  <= w_res_recv;
      r_res_err   <= w_res_err;
      r_res_last  <= w_res_last;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_aborted   <= w_aborted;
      r_main_last <= w_main_last;
      r_sub_last  <= w_sub_last;
      r_dwell     <= w_dwell;
      r_set_cnt   <= w_set_cnt;
      r_dwl_cnt   <= w_dwl_cnt;
    end
  end

  // Next-state and next-output logic; abort overrides everything outside IDLE.
  always_comb begin
    w_state     = r_state;
    w_main      = r_main;
    w_sub       = r_sub;
    w_clr       = r_clr;
    w_res_valid = r_res_valid;
    w_res_main  = r_res_main;
    w_res_sub   = r_res_sub;
    w_res_recv  = r_res_recv;
    w_res_err   = r_res_err;
    w_res_last  = r_res_last;
    w_done      = 1'b0;
    w_aborted   = r_aborted;
    w_main_last = r_main_last;
    w_sub_last  = r_sub_last;
    w_dwell     = r_dwell;
    w_set_cnt   = r_set_cnt;
    w_dwl_cnt   = r_dwl_cnt;

    case (r_state)
      S_IDLE: begin
        w_clr  = 1'b1;
        w_main = IDLE_MODE;
        w_sub  = 8'd0;
        if (START) begin
          w_main_last = MAIN_LAST;
          w_sub_last  = SUB_LAST;
          w_dwell     = (DWELL == DWELL_W'(0)) ? DWELL_W'(1) : DWELL;
          w_aborted   = 1'b0;
          if (MAIN_FIRST > MAIN_LAST) begin
            w_done = 1'b1;
          end else begin
            w_main    = MAIN_FIRST;
            w_sub     = 8'd0;
            w_set_cnt = SET_W'(SETTLE);
            w_state   = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (r_set_cnt == SET_W'(1)) begin
          w_clr     = 1'b0;
          w_dwl_cnt = r_dwell;
          w_state   = S_DWELL;
        end else begin
          w_set_cnt = r_set_cnt - SET_W'(1);
        end
      end
      S_DWELL: begin
        if (r_dwl_cnt == DWELL_W'(1)) begin
          w_res_recv  = RECV_CNT;
          w_res_err   = ERR_CNT;
          w_res_main  = r_main;
          w_res_sub   = r_sub;
          w_res_last  = (r_main == r_main_last) && (r_sub == r_sub_last);
          w_res_valid = 1'b1;
          w_clr       = 1'b1;
          w_state     = S_REPORT;
        end else begin
          w_dwl_cnt = r_dwl_cnt - DWELL_W'(1);
        end
      end
      S_REPORT: begin
        if (r_res_valid && RES_READY) begin
          w_res_valid = 1'b0;
          if (r_res_last) begin
            w_done  = 1'b1;
            w_main  = IDLE_MODE;
            w_sub   = 8'd0;
            w_state = S_IDLE;
          end else begin
            // Advance only while below the bound, so 255 limits never wrap.
            if (r_sub < r_sub_last) begin
              w_sub = r_sub + 8'd1;
            end else begin
              w_sub  = 8'd0;
              w_main = r_main + 8'd1;
            end
            w_set_cnt = SET_W'(SETTLE);
            w_state   = S_SETTLE;
          end
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    if (ABORT && (r_state != S_IDLE)) begin
      w_state     = S_IDLE;
      w_clr       = 1'b1;
      w_main      = IDLE_MODE;
      w_sub       = 8'd0;
      w_res_valid = 1'b0;
      w_aborted   = 1'b1;
      w_done      = 1'b1;
    end

    w_busy = (w_state != S_IDLE);
  end

  assign MAIN_MODE = r_main;
  assign SUB_MODE  = r_sub;
  assign CLR       = r_clr;
  assign RES_VALID = r_res_valid;
  assign RES_MAIN  = r_res_main;
  assign RES_SUB   = r_res_sub;
  assign RES_RECV  = r_res_recv;
  assign RES_ERR   = r_res_err;
  assign RES_LAST  = r_res_last;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign ABORTED   = r_aborted;

endmodule

// File: tb/tb_ber_sweep_seq.sv
// Directed bench for ber_sweep_seq: inputs change and outputs are sampled on the
// falling clock edge; RECV_CNT/ERR_CNT follow a free-running cycle counter.
module tb_ber_sweep_seq;

  logic        CLK = 1'b0;
  logic        RSTX = 1'b1;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic        RES_READY = 1'b1;
  logic [7:0]  MAIN_FIRST = 8'd0;
  logic [7:0]  MAIN_LAST = 8'd0;
  logic [7:0]  SUB_LAST = 8'd0;
  logic [31:0] DWELL = 32'd0;
  logic [57:0] RECV_CNT;
  logic [63:0] ERR_CNT;
  logic [7:0]  MAIN_MODE, SUB_MODE, RES_MAIN, RES_SUB;
  logic        CLR, RES_VALID, RES_LAST, BUSY, DONE, ABORTED;
  logic [57:0] RES_RECV;
  logic [63:0] RES_ERR;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] tbcyc = 32'd0;

  ber_sweep_seq #(.SETTLE(16), .DWELL_W(32), .IDLE_MODE(8'd0)) dut (
    .RSTX(RSTX), .CLK(CLK), .START(START), .ABORT(ABORT),
    .MAIN_FIRST(MAIN_FIRST), .MAIN_LAST(MAIN_LAST), .SUB_LAST(SUB_LAST),
    .DWELL(DWELL), .MAIN_MODE(MAIN_MODE), .SUB_MODE(SUB_MODE), .CLR(CLR),
    .RECV_CNT(RECV_CNT), .ERR_CNT(ERR_CNT), .RES_VALID(RES_VALID),
    .RES_READY(RES_READY), .RES_MAIN(RES_MAIN), .RES_SUB(RES_SUB),
    .RES_RECV(RES_RECV), .RES_ERR(RES_ERR), .RES_LAST(RES_LAST),
    .BUSY(BUSY), .DONE(DONE), .ABORTED(ABORTED)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) tbcyc <= tbcyc + 32'd1;

  assign RECV_CNT = {26'h2A55A5A, tbcyc};
  assign ERR_CNT  = {~tbcyc, tbcyc ^ 32'hDEADBEEF};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] mf, input logic [7:0] ml,
                          input logic [7:0] sl, input logic [31:0] dw);
    MAIN_FIRST = mf; MAIN_LAST = ml; SUB_LAST = sl; DWELL = dw;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  // Counts CLR-high then CLR-low samples; ends on the first sample after the dwell.
  task automatic measure(output int hi, output int lo,
                         output logic [57:0] rv, output logic [63:0] ev);
    hi = 0; lo = 0; rv = '0; ev = '0;
    while (CLR === 1'b1 && hi < 2000) begin hi++; @(negedge CLK); end
    while (CLR === 1'b0 && lo < 2000) begin
      lo++; rv = RECV_CNT; ev = ERR_CNT; @(negedge CLK);
    end
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, lo, n;
    logic [57:0] rv;
    logic [63:0] ev;
    logic ok;
    logic [16:0] lastrec;

    // Reset values
    #2 RSTX = 1'b0;
    @(negedge CLK);
    chk("rst_modes", {MAIN_MODE, SUB_MODE}, 16'h0000);
    chk("rst_flags", {CLR, RES_VALID, RES_LAST, BUSY, DONE, ABORTED}, 6'b100000);
    chk("rst_res", {RES_MAIN, RES_SUB, RES_RECV[47:0]}, 64'd0);
    RSTX = 1'b1;
    repeat (2) @(negedge CLK);

    // Single point 9..9, dwell 100
    do_start(8'd9, 8'd9, 8'd0, 32'd100);
    chk("t1_mode", {MAIN_MODE, SUB_MODE, 7'd0, BUSY}, {8'd9, 8'd0, 8'd1});
    measure(hi, lo, rv, ev);
    chk("t1_clr", {32'(hi), 32'(lo)}, {32'd16, 32'd100});
    chk("t1_rec", {RES_VALID, RES_LAST, RES_MAIN, RES_SUB}, {1'b1, 1'b1, 8'd9, 8'd0});
    chk("t1_recv", 64'(RES_RECV), 64'(rv));
    chk("t1_err", RES_ERR, ev);
    @(negedge CLK);
    chk("t1_done", {DONE, BUSY, RES_VALID, CLR, MAIN_MODE}, {4'b1001, 8'd0});
    @(negedge CLK);
    chk("t1_done_end", DONE, 1'b0);

    // Sweep 13..14 x sub 0..3
    do_start(8'd13, 8'd14, 8'd3, 32'd4);
    for (int p = 0; p < 8; p++) begin
      measure(hi, lo, rv, ev);
      chk("t2_clr", {32'(hi), 32'(lo)}, {32'd16, 32'd4});
      chk("t2_rec", {DONE, RES_VALID, RES_LAST, RES_MAIN, RES_SUB},
          {1'b0, 1'b1, (p == 7), 8'(13 + p / 4), 8'(p % 4)});
      @(negedge CLK);
    end
    chk("t2_done", {DONE, BUSY}, 2'b10);

    // Backpressure: two points, hold first record 50 cycles
    RES_READY = 1'b0;
    do_start(8'd30, 8'd30, 8'd1, 32'd8);
    measure(hi, lo, rv, ev);
    chk("t3_rec", {RES_VALID, RES_LAST, RES_MAIN, RES_SUB}, {1'b1, 1'b0, 8'd30, 8'd0});
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (!(RES_VALID === 1'b1 && RES_RECV === rv && RES_ERR === ev &&
            RES_MAIN === 8'd30 && RES_SUB === 8'd0 && RES_LAST === 1'b0 &&
            CLR === 1'b1 && MAIN_MODE === 8'd30 && SUB_MODE === 8'd0 &&
            BUSY === 1'b1 && DONE === 1'b0)) ok = 1'b0;
    end
    chk("t3_stable", ok, 1'b1);
    RES_READY = 1'b1;
    @(negedge CLK);
    chk("t3_adv", {RES_VALID, CLR, MAIN_MODE, SUB_MODE}, {2'b01, 8'd30, 8'd1});
    measure(hi, lo, rv, ev);
    chk("t3_clr2", {32'(hi), 32'(lo)}, {32'd16, 32'd8});
    chk("t3_rec2", {RES_VALID, RES_LAST, RES_MAIN, RES_SUB}, {1'b1, 1'b1, 8'd30, 8'd1});
    @(negedge CLK);
    chk("t3_done", DONE, 1'b1);

    // Abort mid-dwell
    do_start(8'd5, 8'd6, 8'd2, 32'd40);
    n = 0;
    while (CLR !== 1'b0 && n < 100) begin n++; @(negedge CLK); end
    chk("t4_settle", n, 16);
    repeat (5) @(negedge CLK);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    chk("t4_abort", {BUSY, CLR, ABORTED, DONE, RES_VALID}, 5'b01110);
    chk("t4_modes", {MAIN_MODE, SUB_MODE}, 16'h0000);
    @(negedge CLK);
    chk("t4_pulse", {DONE, ABORTED}, 2'b01);

    // Abort in the same cycle as a handshake
    RES_READY = 1'b0;
    do_start(8'd7, 8'd8, 8'd1, 32'd3);
    measure(hi, lo, rv, ev);
    chk("t5_rec", {RES_VALID, RES_MAIN, RES_SUB}, {1'b1, 8'd7, 8'd0});
    ABORT = 1'b1;
    RES_READY = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    chk("t5_abort", {BUSY, CLR, ABORTED, DONE, RES_VALID}, 5'b01110);
    chk("t5_modes", {MAIN_MODE, SUB_MODE}, 16'h0000);
    @(negedge CLK);
    chk("t5_pulse", {DONE, BUSY}, 2'b00);

    // Empty range: DONE next cycle, ABORTED cleared, no records
    do_start(8'd20, 8'd19, 8'd0, 32'd5);
    chk("t6_done", {DONE, ABORTED, BUSY, RES_VALID, CLR}, 5'b10001);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (DONE !== 1'b0 || BUSY !== 1'b0 || RES_VALID !== 1'b0) ok = 1'b0;
    end
    chk("t6_quiet", ok, 1'b1);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    chk("t6_idle_abort", {ABORTED, DONE, BUSY}, 3'b000);

    // DWELL=0 runs one cycle; inputs latched; START while busy ignored
    do_start(8'd3, 8'd3, 8'd1, 32'd0);
    MAIN_FIRST = 8'd100; MAIN_LAST = 8'd200; SUB_LAST = 8'd9; DWELL = 32'd50;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk("t7_busy_start", {MAIN_MODE, SUB_MODE, 7'd0, BUSY}, {8'd3, 8'd0, 8'd1});
    measure(hi, lo, rv, ev);
    chk("t7_clr0", {32'(hi), 32'(lo)}, {32'd15, 32'd1});
    chk("t7_rec0", {RES_VALID, RES_LAST, RES_MAIN, RES_SUB}, {1'b1, 1'b0, 8'd3, 8'd0});
    @(negedge CLK);
    measure(hi, lo, rv, ev);
    chk("t7_clr1", {32'(hi), 32'(lo)}, {32'd16, 32'd1});
    chk("t7_rec1", {RES_VALID, RES_LAST, RES_MAIN, RES_SUB}, {1'b1, 1'b1, 8'd3, 8'd1});
    chk("t7_recv", 64'(RES_RECV), 64'(rv));
    @(negedge CLK);
    chk("t7_done", {DONE, BUSY}, 2'b10);

    // Full-scale corner 255 x 0..255
    do_start(8'd255, 8'd255, 8'd255, 32'd1);
    ok = 1'b1;
    lastrec = '0;
    for (int p = 0; p < 256; p++) begin
      measure(hi, lo, rv, ev);
      if (hi != 16 || lo != 1 || RES_VALID !== 1'b1 || RES_MAIN !== 8'd255 ||
          RES_SUB !== 8'(p) || RES_LAST !== (p == 255) || DONE !== 1'b0) ok = 1'b0;
      lastrec = {RES_MAIN, RES_SUB, RES_LAST};
      @(negedge CLK);
    end
    chk("t8_seq", ok, 1'b1);
    chk("t8_last", 64'(lastrec), 64'({8'd255, 8'd255, 1'b1}));
    chk("t8_done", {DONE, BUSY, RES_VALID, MAIN_MODE, SUB_MODE}, {3'b100, 16'h0000});
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (RES_VALID !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) ok = 1'b0;
    end
    chk("t8_no_extra", ok, 1'b1);

    // Async reset mid-sweep
    do_start(8'd1, 8'd1, 8'd0, 32'd30);
    repeat (20) @(negedge CLK);
    chk("t9_pre", {CLR, BUSY, MAIN_MODE}, {2'b01, 8'd1});
    #2 RSTX = 1'b0;
    #1;
    chk("t9_rst", {CLR, BUSY, RES_VALID, DONE, MAIN_MODE, SUB_MODE}, {4'b1000, 16'h0000});
    @(negedge CLK);
    RSTX = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (RES_VALID !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0 || CLR !== 1'b1) ok = 1'b0;
    end
    chk("t9_quiet", ok, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
